pr_bus_arbiter: RTL and testbench

PR_BUS_ARBITER -- requirements
Module: pr_bus_arbiter

---
 rtl/pr_bus_arbiter.sv | 104 ++++++++++
 tb/tb_pr_bus_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pr_bus_arbiter.sv
// Round-robin arbiter sharing one device bus between the CPU MEM stage and a
// debug/loader port. A device that never acknowledges is timed out, and the timeout is recorded.
module pr_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  // CPU requester
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:2] c_addr,
  input  logic [31:0] c_wd,
  output logic        c_ack,
  output logic [31:0] c_rd,
  output logic        c_stall,
  // debug/loader requester
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:2] d_addr,
  input  logic [31:0] d_wd,
  output logic        d_ack,
  output logic [31:0] d_rd,
  // shared device bus
  output logic        dev_stb,
  output logic        dev_we,
  output logic [31:2] dev_addr,
  output logic [31:0] dev_wd,
  input  logic        dev_ack,
  input  logic [31:0] dev_rd,
  output logic        bus_err
);

  localparam int unsigned CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {GNT_C = 1'b0, GNT_D = 1'b1} gnt_t;

  state_t        state;
  gnt_t          last_grant;
  logic [CW-1:0] cnt;
  logic [31:0]   result;
  logic          pick_d;

  // D wins only when the CPU is not requesting or the CPU was granted last.
  // NOTE: single unconditional assignment in always_comb, so no latch can be inferred.
  always_comb begin
    pick_d = d_req & (~c_req | (last_grant == GNT_C));
  end

  // NOTE: every register here is edge-updated state, so only non-blocking assignments are used.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GNT_D;
      cnt        <= '0;
      bus_err    <= 1'b0;
      result     <= '0;
      dev_stb    <= 1'b0;
      dev_we     <= 1'b0;
      dev_addr   <= '0;
      dev_wd     <= '0;
      c_ack      <= 1'b0;
      d_ack      <= 1'b0;
    end else begin
      c_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (c_req | d_req) begin
            last_grant <= pick_d ? GNT_D : GNT_C;
            dev_we     <= pick_d ? d_we   : c_we;
            dev_addr   <= pick_d ? d_addr : c_addr;
            dev_wd     <= pick_d ? d_wd   : c_wd;
            cnt        <= '0;
            dev_stb    <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          // Device acknowledge takes priority over a coincident timeout.
          if (dev_ack || cnt == CNT_MAX) begin
            result  <= dev_ack ? dev_rd : ERR_DATA;
            bus_err <= bus_err | ~dev_ack;
            dev_stb <= 1'b0;
            c_ack   <= (last_grant == GNT_C);
            d_ack   <= (last_grant == GNT_D);
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign c_rd    = result;
  assign d_rd    = result;
  assign c_stall = c_req & ~c_ack;

endmodule

// File: tb/tb_pr_bus_arbiter.sv
// Directed bench for pr_bus_arbiter: single reads, round-robin order, writes,
// timeout, ack/timeout coincidence and mid-transaction reset.
module tb_pr_bus_arbiter;

  localparam int unsigned TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_req, c_we, c_ack, c_stall;
  logic [31:2] c_addr;
  logic [31:0] c_wd, c_rd;
  logic        d_req, d_we, d_ack;
  logic [31:2] d_addr;
  logic [31:0] d_wd, d_rd;
  logic        dev_stb, dev_we, dev_ack, bus_err;
  logic [31:2] dev_addr;
  logic [31:0] dev_wd, dev_rd;

  int n_checks = 0;
  int n_fail   = 0;

  // results of the most recent txn() call
  logic        got_c, got_d, bus_we, unstable;
  logic [31:0] got_rd, bus_wd;
  logic [31:2] bus_addr;
  int          stb_n, lat_n, stall_n;

  pr_bus_arbiter #(.TIMEOUT(TIMEOUT), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wd(c_wd),
    .c_ack(c_ack), .c_rd(c_rd), .c_stall(c_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wd(d_wd),
    .d_ack(d_ack), .d_rd(d_rd),
    .dev_stb(dev_stb), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wd(dev_wd),
    .dev_ack(dev_ack), .dev_rd(dev_rd), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    c_req = 0; c_we = 0; c_addr = '0; c_wd = '0;
    d_req = 0; d_we = 0; d_addr = '0; d_wd = '0;
    dev_ack = 0; dev_rd = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Device model: acks on BUSY cycle number lat (1-based); lat=0 never acks.
  // Runs until an ack is seen, with a bounded cycle budget.
  task automatic txn(input int lat, input logic [31:0] rd_val);
    int  busy_n;
    bit  done;
    busy_n = 0; done = 0;
    stb_n = 0; lat_n = 0; stall_n = 0; unstable = 0;
    got_c = 0; got_d = 0; got_rd = '0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      lat_n++;
      dev_ack = 1'b0;
      if (c_ack || d_ack) begin
        got_c  = c_ack;
        got_d  = d_ack;
        got_rd = c_ack ? c_rd : d_rd;
        done   = 1;
      end else if (dev_stb) begin
        busy_n++;
        stb_n++;
        if (c_stall) stall_n++;
        if (busy_n == 1) begin
          bus_we = dev_we; bus_addr = dev_addr; bus_wd = dev_wd;
        end else if (dev_we !== bus_we || dev_addr !== bus_addr || dev_wd !== bus_wd) begin
          unstable = 1;
        end
        if (busy_n == lat) begin
          dev_ack = 1'b1;
          dev_rd  = rd_val;
        end
      end
    end
    if (!done) check("txn_budget", 32'd0, 32'd1);
  endtask

  logic exp_d [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    do_reset();

    // reset state
    check("rst_c_ack",   c_ack,    0);
    check("rst_d_ack",   d_ack,    0);
    check("rst_stb",     dev_stb,  0);
    check("rst_we",      dev_we,   0);
    check("rst_addr",    dev_addr, 0);
    check("rst_wd",      dev_wd,   0);
    check("rst_c_rd",    c_rd,     0);
    check("rst_d_rd",    d_rd,     0);
    check("rst_bus_err", bus_err,  0);

    // CPU read alone
    c_req = 1; c_we = 0; c_addr = 30'h1FC0;
    #1;
    check("rd_stall_idle", c_stall, 1);
    txn(1, 32'h1234_5678);
    check("rd_c_ack",   got_c,    1);
    check("rd_d_ack",   got_d,    0);
    check("rd_data",    got_rd,   32'h1234_5678);
    check("rd_addr",    bus_addr, 30'h1FC0);
    check("rd_we",      bus_we,   0);
    check("rd_latency", lat_n,    2);
    check("rd_stb_n",   stb_n,    1);
    check("rd_stall_busy", stall_n, 1);
    check("rd_stall_done", c_stall, 0);
    tick();
    c_req = 0;
    check("rd_ack_pulse", c_ack, 0);
    check("rd_idle_stb",  dev_stb, 0);

    // round robin after reset: C, D, C, D
    do_reset();
    c_req = 1; c_addr = 30'h100; d_req = 1; d_addr = 30'h200;
    for (int k = 0; k < 4; k++) begin
      txn(1, 32'hC0DE_0000 + 32'(k));
      check("rr_c_ack", got_c, {31'd0, ~exp_d[k]});
      check("rr_d_ack", got_d, {31'd0, exp_d[k]});
      check("rr_addr",  bus_addr, exp_d[k] ? 30'h200 : 30'h100);
      check("rr_data",  got_rd, 32'hC0DE_0000 + 32'(k));
    end
    tick();
    c_req = 0; d_req = 0;

    // D write, device ack on 4th BUSY cycle
    tick();
    d_req = 1; d_we = 1; d_addr = 30'h0ABC; d_wd = 32'hA5A5_0001;
    txn(4, 32'h0000_0000);
    check("wr_d_ack",   got_d,    1);
    check("wr_c_ack",   got_c,    0);
    check("wr_stb_n",   stb_n,    4);
    check("wr_we",      bus_we,   1);
    check("wr_wd",      bus_wd,   32'hA5A5_0001);
    check("wr_stable",  unstable, 0);
    tick();
    d_req = 0; d_we = 0;

    // timeout, then bus_err stays set through a good transaction
    tick();
    c_req = 1; c_we = 0; c_addr = 30'h3000;
    txn(0, 32'h0);
    check("to_c_ack",   got_c,   1);
    check("to_data",    got_rd,  32'hDEAD_BEEF);
    check("to_stb_n",   stb_n,   TIMEOUT + 1);
    check("to_latency", lat_n,   TIMEOUT + 2);
    check("to_bus_err", bus_err, 1);
    check("to_stable",  unstable, 0);
    tick();
    c_req = 0;
    tick();
    c_req = 1;
    txn(2, 32'h0BAD_F00D);
    check("post_to_data", got_rd,  32'h0BAD_F00D);
    check("post_to_err",  bus_err, 1);
    tick();
    c_req = 0;

    // ack coincides with counter reaching TIMEOUT
    do_reset();
    check("coin_err_cleared", bus_err, 0);
    c_req = 1; c_addr = 30'h0044;
    txn(TIMEOUT + 1, 32'h5555_AAAA);
    check("coin_data",  got_rd,  32'h5555_AAAA);
    check("coin_err",   bus_err, 0);
    check("coin_stb_n", stb_n,   TIMEOUT + 1);
    tick();
    c_req = 0;

    // reset in the second BUSY cycle
    tick();
    c_req = 1; c_addr = 30'h0777;
    tick();
    check("abort_busy1", dev_stb, 1);
    tick();
    check("abort_busy2", dev_stb, 1);
    rst = 1; c_req = 0;
    tick();
    rst = 0;
    check("abort_stb",   dev_stb,  0);
    check("abort_c_ack", c_ack,    0);
    check("abort_d_ack", d_ack,    0);
    check("abort_addr",  dev_addr, 0);
    tick();
    check("abort_no_ack", c_ack, 0);
    c_req = 1; c_addr = 30'h0888;
    txn(1, 32'hFEED_0001);
    check("fresh_c_ack",   got_c,  1);
    check("fresh_data",    got_rd, 32'hFEED_0001);
    check("fresh_latency", lat_n,  2);
    tick();
    c_req = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
